mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares one burst-oriented memory command/data port among NUM_REQ requesters: requester 0 = icache refill, 1 = dcache refill/writeback, 2 = graphics processor fetch.
- Sits between the cache/GP block and the memory controller.
- Sequences each transaction as a command phase followed by a fixed-length data burst, with round-robin fairness and the grant locked for the whole burst.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data beat width.
- BURST_LEN, 4, beats per transaction (power of two, 2..16).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_we  in  NUM_REQ  1 = write burst, 0 = read burst.
- req_addr  in  NUM_REQ*ADDR_W  packed burst-aligned addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot; request accepted this cycle.
- req_wdata  in  NUM_REQ*DATA_W  packed write beats.
- req_wdata_ready  out  NUM_REQ  one-hot; the granted requester's beat is consumed.
- req_rdata  out  DATA_W  broadcast read beat.
- req_rdata_valid  out  NUM_REQ  one-hot; beat belongs to this requester.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  controller accepts command.
- mem_cmd_we  out  1  write command.
- mem_cmd_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  write beat.
- mem_wdata_valid  out  1  write beat valid.
- mem_wdata_ready  in  1  controller accepts write beat.
- mem_rdata  in  DATA_W  read beat.
- mem_rdata_valid  in  1  read beat valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, grant 0, rr_ptr 0, beat_cnt 0. All outputs 0: req_ready, req_wdata_ready, req_rdata_valid, mem_cmd_valid, mem_wdata_valid, busy, mem_cmd_addr, mem_cmd_we, req_rdata.
- Reset mid-burst abandons the transaction. No beats are replayed after reset release.
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE:
  - Selects the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - If any is found: latch grant index, addr, and we; pulse req_ready[grant] for exactly one cycle; go to CMD.
  - Requester inputs are ignored after the pulse.
- CMD:
  - mem_cmd_valid=1 with the latched addr/we, held stable until mem_cmd_ready.
  - On acceptance: go to WDATA if we, else RDATA; beat_cnt=0.
- WDATA:
  - mem_wdata = req_wdata slice of grant.
  - mem_wdata_valid=1.
  - req_wdata_ready[grant] = mem_wdata_ready (combinational pass-through).
  - Each accepted beat increments beat_cnt.
  - The beat with beat_cnt==BURST_LEN-1 ends the burst.
- RDATA:
  - req_rdata = mem_rdata and req_rdata_valid[grant] = mem_rdata_valid, both registered: 1-cycle latency.
  - Each valid beat increments beat_cnt.
  - mem_rdata_valid is ignored outside RDATA.
- Burst end:
  - Return to IDLE; rr_ptr = (grant+1) mod NUM_REQ.
  - The next grant can be issued the cycle after return to IDLE (minimum 1 idle cycle between bursts).
- Round-robin guarantees no requester waits more than NUM_REQ-1 bursts.
- Simultaneous requests in IDLE: the rr_ptr search order decides.
- Request deasserted before its grant: no effect.
- Address is not checked for alignment. Low log2(BURST_LEN*DATA_W/8) bits pass through unchanged.
- beat_cnt width is clog2(BURST_LEN).
- Wrap of beat_cnt at BURST_LEN-1 is the end condition; no overflow state exists.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams ST_IDLE/ST_CMD/ST_WDATA/ST_RDATA;
  - requester index constants REQ_ICACHE=0, REQ_DCACHE=1, REQ_GP=2.
- One natural sub-module, rr_priority_pick:
  - combinational one-hot round-robin selector;
  - inputs: request vector, rr_ptr;
  - outputs: one-hot grant, grant index, any.

Test Plan:
- Single read: req_valid=3'b001, addr 0x1000, mem returns beats A0..A3 after cmd_ready → req_ready[0] pulses once; mem_cmd_addr=0x1000, we=0; req_rdata_valid[0] high 4 cycles, each 1 cycle after mem_rdata_valid; busy drops after beat 3.
- Write with backpressure: requester 1 writes 0x2000, mem_wdata_ready toggles 1,0,1,0,1,1 → exactly 4 beats transferred; req_wdata_ready mirrors ready; returns IDLE.
- Fairness: all three requesters held valid for 6 bursts from reset → grant order 0,1,2,0,1,2.
- Cmd stall: mem_cmd_ready low 5 cycles → mem_cmd_valid/addr/we stable throughout; no data-phase activity.
- Async reset mid-RDATA after beat 1: rst low → all outputs 0 immediately. After release, new req from requester 2 → granted first (rr_ptr=0 search finds 2); stale mem_rdata_valid is ignored in IDLE.
- Spurious read data: mem_rdata_valid pulsed in IDLE and WDATA → req_rdata_valid stays 0.

Source files
------------

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared definitions for the MIPS memory arbiter: FSM state encoding and
// the fixed requester index assignment.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } arb_state_e;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_GP     = 2;

endpackage

// File: rtl/mips_mem_arbiter_pick.sv
// Combinational round-robin selector: finds the first set request bit,
// scanning upward from ptr_i with wrap-around.
module rr_priority_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_onehot_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found        = 1'b0;
    cand         = '0;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found              = 1'b1;
        gnt_idx_o          = cand;
        gnt_onehot_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between the icache,
// dcache and graphics processor; grant is held for the whole burst.
module mips_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_wdata_ready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_rdata_valid,
  output logic                      mem_cmd_valid,
  input  logic                      mem_cmd_ready,
  output logic                      mem_cmd_we,
  output logic [ADDR_W-1:0]         mem_cmd_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wdata_valid,
  input  logic                      mem_wdata_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_rdata_valid,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [CNT_W-1:0]    beat_cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [NUM_REQ-1:0]  rvalid_q;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                last_beat;
  logic                in_wdata;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (req_valid),
    .ptr_i        (rr_ptr_q),
    .gnt_onehot_o (pick_onehot),
    .gnt_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  assign grant_onehot = NUM_REQ'(1) << grant_q;
  assign beat_cnt_d   = beat_cnt_q + CNT_W'(1);
  assign last_beat    = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign rr_ptr_d     = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // Requester inputs are sampled only in IDLE; afterwards the latched
  // grant/addr/we drive the burst until its last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      req_ready_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
    end else begin
      req_ready_q <= '0;
      rvalid_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_idx;
            addr_q      <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            we_q        <= req_we[pick_idx];
            req_ready_q <= pick_onehot;
            state_q     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_cmd_ready) begin
            beat_cnt_q <= '0;
            state_q    <= we_q ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (mem_wdata_ready) begin
            beat_cnt_q <= beat_cnt_d;
            if (last_beat) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        ST_RDATA: begin
          if (mem_rdata_valid) begin
            rdata_q    <= mem_rdata;
            rvalid_q   <= grant_onehot;
            beat_cnt_q <= beat_cnt_d;
            if (last_beat) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write beats pass straight through so the controller's ready throttles
  // the granted requester in the same cycle.
  assign in_wdata        = (state_q == ST_WDATA);
  assign mem_wdata_valid = in_wdata;
  assign mem_wdata       = in_wdata ? req_wdata[int'(grant_q)*DATA_W +: DATA_W] : '0;
  assign req_wdata_ready = (in_wdata && mem_wdata_ready) ? grant_onehot : '0;

  assign mem_cmd_valid   = (state_q == ST_CMD);
  assign mem_cmd_addr    = addr_q;
  assign mem_cmd_we      = we_q;
  assign busy            = (state_q != ST_IDLE);
  assign req_ready       = req_ready_q;
  assign req_rdata       = rdata_q;
  assign req_rdata_valid = rvalid_q;

endmodule
